// File: rtl/fifo_shift_sync.sv
// Single-clock FIFO with occupancy counts and almost-full/almost-empty flags.
// Define FIFO_SHIFT_OUTPUT_REG_EN to add a second read-data register (2-cycle read latency).
module fifo_shift_sync #(
    parameter int unsigned DEPTH_WIDTH      = 11,
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned ALMOST_FULL_NUM  = 1919,
    parameter int unsigned ALMOST_EMPTY_NUM = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   wr_full,
    output logic [DEPTH_WIDTH:0]   wr_water_level,
    output logic                   almost_full,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   rd_en,
    output logic                   rd_empty,
    output logic [DEPTH_WIDTH:0]   rd_water_level,
    output logic                   almost_empty
);

    localparam int unsigned Depth = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0]   FullCount = (DEPTH_WIDTH+1)'(Depth);
    localparam logic [DEPTH_WIDTH:0]   AfCount   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0]   AeCount   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
    localparam logic [DEPTH_WIDTH:0]   CntOne    = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] PtrOne    = DEPTH_WIDTH'(1);

    logic [DATA_WIDTH-1:0]  mem [Depth];
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_WIDTH:0]   count_q, count_d;
    logic                   wr_full_q, rd_empty_q, almost_full_q, almost_empty_q;
    logic [DATA_WIDTH-1:0]  ram_rd_q;
    logic                   wr_accept, rd_accept;

    // Acceptance looks only at the registered flags, so a read cannot free room for a
    // write in the same cycle.
    assign wr_accept = wr_en & ~wr_full_q;
    assign rd_accept = rd_en & ~rd_empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_empty_q <= 1'b1;
        end else begin
            if (wr_accept) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (rd_accept) rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q        <= count_d;
            wr_full_q      <= (count_d == FullCount);
            almost_full_q  <= (count_d >= AfCount);
            rd_empty_q     <= (count_d == '0);
            almost_empty_q <= (count_d <= AeCount);
        end
    end

    // RAM array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_rd_q <= '0;
        end else if (rd_accept) begin
            ram_rd_q <= mem[rd_ptr_q];
        end
    end

`ifdef FIFO_SHIFT_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= ram_rd_q;
        end
    end

    assign rd_data = out_q;
`else
    assign rd_data = ram_rd_q;
`endif

    assign wr_full        = wr_full_q;
    assign almost_full    = almost_full_q;
    assign rd_empty       = rd_empty_q;
    assign almost_empty   = almost_empty_q;
    assign wr_water_level = count_q;
    assign rd_water_level = count_q;

endmodule

// File: tb/tb_fifo_shift_sync.sv
// Directed self-checking bench for fifo_shift_sync (default 2048 x 8 configuration).
module tb_fifo_shift_sync;

    localparam int DW    = 11;
    localparam int DEPTH = 2048;
`ifdef FIFO_SHIFT_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          tb_rst;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          wr_full;
    logic [DW:0]   wr_water_level;
    logic          almost_full;
    logic [7:0]    rd_data;
    logic          rd_en;
    logic          rd_empty;
    logic [DW:0]   rd_water_level;
    logic          almost_empty;

    int vectors    = 0;
    int miscompares = 0;

    fifo_shift_sync dut (
        .clk            (clk),
        .rst            (tb_rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // flags packed as {wr_full, almost_full, rd_empty, almost_empty}
    task automatic test_reset;
        tb_rst  = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            vectors++;
            if ({wr_full, almost_full, rd_empty, almost_empty} !== 4'b0011) begin
                $display("FAIL reset_flags pass=%0d got %b want 0011", pass,
                         {wr_full, almost_full, rd_empty, almost_empty});
                miscompares++;
            end
            vectors++;
            if (wr_water_level !== '0 || rd_water_level !== '0 || rd_data !== 8'h00) begin
                $display("FAIL reset_levels pass=%0d got wl=%0d rl=%0d rd=%0h want 0 0 0", pass,
                         wr_water_level, rd_water_level, rd_data);
                miscompares++;
            end
            tb_rst = 1'b0;
            tick();
        end
    endtask

    task automatic test_fill;
        logic [DW:0] exp_lvl;
        logic [3:0]  exp_flags;
        for (int k = 0; k <= DEPTH; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'(255 - k);
            tick();
            exp_lvl   = (k + 1 > DEPTH) ? (DW+1)'(DEPTH) : (DW+1)'(k + 1);
            exp_flags = {exp_lvl == (DW+1)'(DEPTH), exp_lvl >= (DW+1)'(1919), 1'b0,
                         exp_lvl <= (DW+1)'(1)};
            vectors++;
            if (wr_water_level !== exp_lvl || rd_water_level !== exp_lvl) begin
                $display("FAIL fill_level k=%0d got wl=%0d rl=%0d want %0d", k,
                         wr_water_level, rd_water_level, exp_lvl);
                miscompares++;
            end
            vectors++;
            if ({wr_full, almost_full, rd_empty, almost_empty} !== exp_flags) begin
                $display("FAIL fill_flags k=%0d got %b want %b", k,
                         {wr_full, almost_full, rd_empty, almost_empty}, exp_flags);
                miscompares++;
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_drain;
        logic [DW:0] exp_lvl;
        int idx;
        rd_en = 1'b1;
        for (int i = 1; i <= DEPTH + LAT; i++) begin
            tick();
            idx = i - LAT;
            if (idx >= 0) begin
                vectors++;
                if (rd_data !== 8'(255 - ((idx > DEPTH - 1) ? DEPTH - 1 : idx))) begin
                    $display("FAIL drain_data i=%0d got %0h want %0h", i, rd_data,
                             8'(255 - ((idx > DEPTH - 1) ? DEPTH - 1 : idx)));
                    miscompares++;
                end
            end
            exp_lvl = (i >= DEPTH) ? '0 : (DW+1)'(DEPTH - i);
            vectors++;
            if (wr_water_level !== exp_lvl || rd_water_level !== exp_lvl) begin
                $display("FAIL drain_level i=%0d got %0d want %0d", i, rd_water_level, exp_lvl);
                miscompares++;
            end
            vectors++;
            if (rd_empty !== (i >= DEPTH) || almost_empty !== (i >= DEPTH - 1) ||
                wr_full !== 1'b0 || almost_full !== (DEPTH - i >= 1919)) begin
                $display("FAIL drain_flags i=%0d got %b", i,
                         {wr_full, almost_full, rd_empty, almost_empty});
                miscompares++;
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_simultaneous;
        for (int k = 0; k < 5; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'(10 + k);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            wr_data = 8'(15 + i - 1);
            tick();
            vectors++;
            if (rd_water_level !== (DW+1)'(5) ||
                {wr_full, almost_full, rd_empty, almost_empty} !== 4'b0000) begin
                $display("FAIL simul_state i=%0d got lvl=%0d flags=%b want 5 0000", i,
                         rd_water_level, {wr_full, almost_full, rd_empty, almost_empty});
                miscompares++;
            end
            if (i >= LAT) begin
                vectors++;
                if (rd_data !== 8'(10 + i - LAT)) begin
                    $display("FAIL simul_data i=%0d got %0h want %0h", i, rd_data,
                             8'(10 + i - LAT));
                    miscompares++;
                end
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        // 5 entries remain from the previous scenario.
        for (int k = 0; k < 995; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'(k);
            tick();
        end
        wr_en = 1'b0;
        vectors++;
        if (wr_water_level !== (DW+1)'(1000)) begin
            $display("FAIL mid_level got %0d want 1000", wr_water_level);
            miscompares++;
        end
        tb_rst = 1'b1;
        #1;
        vectors++;
        if ({wr_full, almost_full, rd_empty, almost_empty} !== 4'b0011 ||
            wr_water_level !== '0 || rd_water_level !== '0 || rd_data !== 8'h00) begin
            $display("FAIL mid_async_reset got flags=%b wl=%0d rl=%0d rd=%0h want 0011 0 0 0",
                     {wr_full, almost_full, rd_empty, almost_empty},
                     wr_water_level, rd_water_level, rd_data);
            miscompares++;
        end
        tick();
        tb_rst = 1'b0;
        tick();
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        vectors++;
        if (wr_water_level !== (DW+1)'(1) || rd_empty !== 1'b0) begin
            $display("FAIL mid_write got lvl=%0d empty=%b want 1 0", wr_water_level, rd_empty);
            miscompares++;
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        repeat (LAT - 1) tick();
        vectors++;
        if (rd_data !== 8'hA5 || rd_water_level !== '0 || rd_empty !== 1'b1) begin
            $display("FAIL mid_read got rd=%0h lvl=%0d empty=%b want a5 0 1", rd_data,
                     rd_water_level, rd_empty);
            miscompares++;
        end
    endtask

    task automatic test_wrap;
        int idx;
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 1024; k++) begin
                wr_en   = 1'b1;
                wr_data = 8'(k + rep * 85);
                tick();
            end
            wr_en = 1'b0;
            vectors++;
            if (wr_water_level !== (DW+1)'(1024)) begin
                $display("FAIL wrap_fill rep=%0d got %0d want 1024", rep, wr_water_level);
                miscompares++;
            end
            rd_en = 1'b1;
            for (int i = 1; i <= 1024 + LAT - 1; i++) begin
                tick();
                idx = i - LAT;
                if (idx >= 0) begin
                    vectors++;
                    if (rd_data !== 8'(idx + rep * 85)) begin
                        $display("FAIL wrap_data rep=%0d idx=%0d got %0h want %0h", rep, idx,
                                 rd_data, 8'(idx + rep * 85));
                        miscompares++;
                    end
                end
            end
            rd_en = 1'b0;
            vectors++;
            if (rd_empty !== 1'b1 || rd_water_level !== '0) begin
                $display("FAIL wrap_empty rep=%0d got empty=%b lvl=%0d want 1 0", rep,
                         rd_empty, rd_water_level);
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_shift_sync.md
# fifo_shift_sync

Single-clock first-in/first-out buffer, 2048 × 8 bits by default, used as the line/shift buffer in the HDMI board video path. Writes and reads share one clock. It reports full/empty flags, occupancy counts on both sides, and programmable almost-full/almost-empty thresholds. Read data is registered out of block RAM with one-cycle latency; an optional output register adds a second stage.

## Interface
Parameters:
- DEPTH_WIDTH, 11, log2 of entry count (DEPTH = 2**DEPTH_WIDTH = 2048).
- DATA_WIDTH, 8, width of write and read data (equal on both sides).
- ALMOST_FULL_NUM, 1919, almost_full threshold in entries.
- ALMOST_EMPTY_NUM, 1, almost_empty threshold in entries.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_data  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- wr_full  out  1  FIFO holds DEPTH entries.
- wr_water_level  out  DEPTH_WIDTH+1  current occupancy, 0..DEPTH.
- almost_full  out  1  occupancy >= ALMOST_FULL_NUM.
- rd_data  out  DATA_WIDTH  read data.
- rd_en  in  1  read request.
- rd_empty  out  1  FIFO holds 0 entries.
- rd_water_level  out  DEPTH_WIDTH+1  current occupancy (same value as wr_water_level).
- almost_empty  out  1  occupancy <= ALMOST_EMPTY_NUM.

## Operation
- Storage is a DEPTH × DATA_WIDTH simple dual-port RAM with a synchronous read port.
- Write pointer and read pointer are DEPTH_WIDTH bits wide and wrap from DEPTH-1 to 0. The occupancy counter is DEPTH_WIDTH+1 bits wide.
- A write is accepted when wr_en=1 and wr_full=0. The RAM entry at the write pointer takes wr_data and the write pointer increments.
- A read is accepted when rd_en=1 and rd_empty=0. The RAM entry at the read pointer is loaded into rd_data and the read pointer increments.
- A write while full is dropped and leaves pointers and count unchanged. The same applies to a read while empty, and rd_data holds its last value.
- Acceptance uses the registered wr_full/rd_empty flags. A write while full is rejected even if a read is accepted in the same cycle.
- Count update per cycle: +1 for a write only, −1 for a read only, unchanged when both or neither are accepted.
- Flags are registered from the next-state count:
  - wr_full = (count == DEPTH).
  - rd_empty = (count == 0).
  - almost_full = (count >= ALMOST_FULL_NUM).
  - almost_empty = (count <= ALMOST_EMPTY_NUM).
- wr_water_level and rd_water_level both equal the registered count.
- Reset values: pointers 0, count 0, wr_full 0, almost_full 0, rd_empty 1, almost_empty 1, both water levels 0, rd_data 0.
- Reset mid-operation discards all contents immediately. RAM contents are not cleared.

## Timing
- Write: wr_data sampled on the clock edge where wr_en=1. Count and flags reflect the write after that same edge.
- Read latency, default build: rd_data is valid in the cycle after the rd_en cycle, so data read in cycle N is stable in cycle N+1.
- Data ordering is strict FIFO.
- Back-to-back reads with rd_en held high stream one word per cycle.
- Full boundary: after DEPTH accepted writes, wr_full=1 in the following cycle. The (DEPTH+1)-th consecutive write is dropped.
- Empty boundary: the last valid read sets rd_empty=1 after that edge. A further read leaves rd_data unchanged.

## Configuration
- Macro FIFO_SHIFT_OUTPUT_REG_EN.
- When defined: an extra output register follows the RAM read data, so read latency is 2 cycles. That register loads every cycle, and its reset value is 0.
- When undefined (default): read latency is 1 cycle as described above.
- Flags and counts are identical in both builds.

## Test plan
- Reset with no traffic -> rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, water levels 0, rd_data=0.
- Write 2049 consecutive cycles with data 255, 254, 253, … (mod 256) ->
  - almost_empty deasserts after the 2nd write.
  - almost_full asserts after write 1919.
  - wr_full=1 and level=2048 after write 2048.
  - The 2049th write is dropped.
- Read 2049 consecutive cycles -> rd_data is 255, 254, … (mod 256) with 1-cycle latency (2 with FIFO_SHIFT_OUTPUT_REG_EN) for 2048 words. rd_empty=1 after the 2048th read, and the extra read holds rd_data.
- Simultaneous wr_en and rd_en at level 5 for 100 cycles -> level stays 5, output order is preserved, and no flag toggles.
- Assert rst while level=1000 -> all outputs return to reset values asynchronously. A subsequent write/read of 0xA5 returns 0xA5 in order.
- Pointer wrap: fill to 1024, drain 1024, repeat 3 times with an incrementing pattern -> no data mismatch across the pointer wrap.
